// File: rtl/am2928_ctl_pkg.sv
// Shared types and constants for the am2928 bus-transfer controller.
// Optional build macro AM2928_CTL_FIXPRIO_EN selects fixed-priority arbitration.
package am2928_ctl_pkg;

    // Controller states; encoding is explicit so debug dumps stay stable.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRIVE = 2'd2,
        TURNA = 2'd3
    } state_t;

    // Width of the turnaround counter; TURN is limited to 0..7.
    localparam int TCW = 3;

    // Width of one port-index field for n ports (never narrower than one bit).
    function automatic int sel_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/am2928_ctl_if.sv
// Bus bundle between the controller and the am2928 port array.
// master: the controller (drives port controls, receives requests).
// slave : the port side (drives requests, receives port controls).
interface am2928_ctl_if
    import am2928_ctl_pkg::*;
#(
    parameter int NREQ = 4
);
    localparam int SW = sel_width(NREQ);

    logic [NREQ-1:0]    req;
    logic [NREQ*SW-1:0] dst;
    logic [NREQ-1:0]    endr_;
    logic [NREQ-1:0]    enrec_;
    logic [NREQ-1:0]    be_;
    logic [NREQ-1:0]    oe_;
    logic [NREQ-1:0]    s;
    logic [NREQ-1:0]    ack;
    logic               err;
    logic               busy;

    modport master (
        input  req, dst,
        output endr_, enrec_, be_, oe_, s, ack, err, busy
    );

    modport slave (
        output req, dst,
        input  endr_, enrec_, be_, oe_, s, ack, err, busy
    );

endinterface

// File: rtl/am2928_rrarb.sv
// Winner selection for the am2928 controller.
// Default: round-robin, searching upward from ptr+1 (mod NREQ).
// With AM2928_CTL_FIXPRIO_EN defined: lowest requesting index wins, no pointer.
module am2928_rrarb
    import am2928_ctl_pkg::*;
#(
    parameter int NREQ = 4,
    localparam int SW = sel_width(NREQ)
)
(
    input  logic [NREQ-1:0] req,
`ifndef AM2928_CTL_FIXPRIO_EN
    input  logic [SW-1:0]   ptr,
`endif
    output logic [NREQ-1:0] grant,
    output logic [SW-1:0]   win,
    output logic            any
);

    // Walk candidates from lowest to highest priority so the last hit is the winner.
    always_comb begin
        int idx;
        int widx;
        idx  = 0;
        widx = 0;
`ifdef AM2928_CTL_FIXPRIO_EN
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx  = i;
            widx = req[idx] ? idx : widx;
        end
`else
        for (int off = NREQ; off >= 1; off--) begin
            idx  = (int'(ptr) + off) % NREQ;
            widx = req[idx] ? idx : widx;
        end
`endif
        any = |req;
        win = SW'(widx);
        for (int i = 0; i < NREQ; i++) begin
            grant[i] = any & (widx == i);
        end
    end

endmodule

// File: rtl/am2928_ctl.sv
// am2928 shared-bus transfer controller (top).
// Sequence per transfer: IDLE -> LOAD (source latches d) -> DRIVE (source drives
// bus, destination receives, ack) -> TURNA x TURN -> IDLE.
// All outputs are registered from the next-state decode.
// Optional build macro AM2928_CTL_FIXPRIO_EN: fixed-priority arbitration.
module am2928_ctl
    import am2928_ctl_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int TURN = 1
)
(
    input  logic         cp,
    input  logic         rst,
    am2928_ctl_if.master bus
);

    localparam int SW  = sel_width(NREQ);
    localparam int SW1 = SW + 1;
    localparam logic [SW:0]      NREQ_W    = SW1'(NREQ);
    localparam logic [TCW-1:0]   TURN_LAST = (TURN > 0) ? TCW'(TURN - 1) : {TCW{1'b0}};
    localparam logic [TCW-1:0]   CNT_ZERO  = {TCW{1'b0}};
    localparam logic [TCW-1:0]   CNT_ONE   = {{(TCW-1){1'b0}}, 1'b1};
    localparam logic [NREQ-1:0]  ALL_HI    = {NREQ{1'b1}};
    localparam logic [NREQ-1:0]  ALL_LO    = {NREQ{1'b0}};

    state_t          state_r, state_n;
    logic [SW-1:0]   src_r, src_n;
    logic [SW-1:0]   dstl_r, dstl_n;
    logic [TCW-1:0]  cnt_r, cnt_n;
`ifndef AM2928_CTL_FIXPRIO_EN
    logic [SW-1:0]   ptr_r, ptr_n;
`endif

    logic [NREQ-1:0] grant_s;
    logic [SW-1:0]   win_s;
    logic            any_s;
    logic [SW-1:0]   dst_sel_s;
    logic            dst_ok_s;
    logic            close_s;
    logic            rej_s;

    logic [NREQ-1:0] endr_r, enrec_r, be_r, oe_r, ack_r;
    logic [NREQ-1:0] endr_n, enrec_n, be_n, oe_n, ack_n;
    logic            err_r, busy_r;

    am2928_rrarb #(.NREQ(NREQ)) u_arb (
        .req   (bus.req),
`ifndef AM2928_CTL_FIXPRIO_EN
        .ptr   (ptr_r),
`endif
        .grant (grant_s),
        .win   (win_s),
        .any   (any_s)
    );

    assign dst_sel_s = bus.dst[int'(win_s) * SW +: SW];
    assign dst_ok_s  = ({1'b0, dst_sel_s} < NREQ_W);

    // The edge that ends a transfer also acts as the IDLE sampling edge, so
    // back-to-back transfers take LOAD + DRIVE + TURN cycles with no idle gap.
    assign close_s = ((state_r == DRIVE) && (TURN == 0)) ||
                     ((state_r == TURNA) && (cnt_r == CNT_ZERO));

    // Next-state, latched transfer fields and arbitration outcome.
    always_comb begin
        state_n = state_r;
        src_n   = src_r;
        dstl_n  = dstl_r;
        cnt_n   = cnt_r;
        rej_s   = 1'b0;
`ifndef AM2928_CTL_FIXPRIO_EN
        ptr_n   = ptr_r;
`endif
        case (state_r)
            IDLE:  state_n = IDLE;
            LOAD:  state_n = DRIVE;
            DRIVE: begin
                if (TURN == 0) begin
                    state_n = IDLE;
                end else begin
                    state_n = TURNA;
                    cnt_n   = TURN_LAST;
                end
            end
            TURNA: begin
                if (cnt_r == CNT_ZERO) begin
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt_r - CNT_ONE;
                end
            end
            default: state_n = IDLE;
        endcase

        if (((state_r == IDLE) || close_s) && any_s) begin
`ifndef AM2928_CTL_FIXPRIO_EN
            ptr_n = win_s;
`endif
            if (dst_ok_s) begin
                state_n = LOAD;
                src_n   = win_s;
                dstl_n  = dst_sel_s;
            end else begin
                state_n = IDLE;
                rej_s   = 1'b1;
            end
        end else begin
            rej_s = 1'b0;
        end
    end

    // Moore decode of the upcoming state into per-port control values.
    always_comb begin
        endr_n  = ALL_HI;
        enrec_n = ALL_HI;
        be_n    = ALL_HI;
        oe_n    = oe_r;
        ack_n   = ALL_LO;
        for (int i = 0; i < NREQ; i++) begin
            endr_n[i]  = ~((state_n == LOAD)  && (src_n  == SW'(i)));
            be_n[i]    = ~((state_n == DRIVE) && (src_n  == SW'(i)));
            enrec_n[i] = ~((state_n == DRIVE) && (dstl_n == SW'(i)));
            ack_n[i]   = ((state_n == DRIVE) && (src_n == SW'(i))) || (rej_s && grant_s[i]);
            oe_n[i]    = (state_r == DRIVE) ? (dstl_r != SW'(i)) : oe_r[i];
        end
    end

    // State and output registers; reset idles the bus immediately.
    always_ff @(posedge cp or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            src_r   <= {SW{1'b0}};
            dstl_r  <= {SW{1'b0}};
            cnt_r   <= CNT_ZERO;
`ifndef AM2928_CTL_FIXPRIO_EN
            ptr_r   <= SW'(NREQ - 1);
`endif
            endr_r  <= ALL_HI;
            enrec_r <= ALL_HI;
            be_r    <= ALL_HI;
            oe_r    <= ALL_HI;
            ack_r   <= ALL_LO;
            err_r   <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_n;
            src_r   <= src_n;
            dstl_r  <= dstl_n;
            cnt_r   <= cnt_n;
`ifndef AM2928_CTL_FIXPRIO_EN
            ptr_r   <= ptr_n;
`endif
            endr_r  <= endr_n;
            enrec_r <= enrec_n;
            be_r    <= be_n;
            oe_r    <= oe_n;
            ack_r   <= ack_n;
            err_r   <= rej_s;
            busy_r  <= (state_n != IDLE);
        end
    end

    assign bus.endr_  = endr_r;
    assign bus.enrec_ = enrec_r;
    assign bus.be_    = be_r;
    assign bus.oe_    = oe_r;
    assign bus.s      = ALL_LO;
    assign bus.ack    = ack_r;
    assign bus.err    = err_r;
    assign bus.busy   = busy_r;

endmodule

// File: tb/tb_am2928_ctl.sv
// Directed bench for am2928_ctl: three instances (NREQ=4/TURN=1, NREQ=3/TURN=1,
// NREQ=4/TURN=0) share one clock and reset. Expected ack sources go into a
// queue as requests are raised and are popped as the DUT acknowledges.
module tb_am2928_ctl;

    logic cp;
    logic rst;
    int   n_cmp;
    int   n_bad;
    int   q[$];

    am2928_ctl_if #(.NREQ(4)) ifa ();
    am2928_ctl_if #(.NREQ(3)) ifb ();
    am2928_ctl_if #(.NREQ(4)) ifc ();

    am2928_ctl #(.NREQ(4), .TURN(1)) dut_a (.cp(cp), .rst(rst), .bus(ifa));
    am2928_ctl #(.NREQ(3), .TURN(1)) dut_b (.cp(cp), .rst(rst), .bus(ifb));
    am2928_ctl #(.NREQ(4), .TURN(0)) dut_c (.cp(cp), .rst(rst), .bus(ifc));

    initial cp = 1'b0;
    always #5 cp = ~cp;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete (observed running, expected done)");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge cp);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic view(input int which, output logic [3:0] a, output logic [3:0] b,
                        output logic [3:0] so);
        case (which)
            0: begin a = ifa.ack; b = ifa.be_; so = ifa.s; end
            1: begin a = {1'b0, ifb.ack}; b = {1'b1, ifb.be_}; so = {1'b0, ifb.s}; end
            default: begin a = ifc.ack; b = ifc.be_; so = ifc.s; end
        endcase
    endtask

    // Consume n acks from DUT 'which', checking source, spacing and bus rules.
    task automatic run_stream(input int which, input int n, input int gap, input int budget);
        int got;
        int last;
        int e;
        logic [3:0] a, b, so;
        got  = 0;
        last = 0;
        for (int c = 0; c < budget && got < n; c++) begin
            step();
            view(which, a, b, so);
            chk("be_one_low", 32'($countones(~b) <= 1), 32'd1);
            chk("s_zero", {28'd0, so}, 32'd0);
            if (a != 4'd0) begin
                if (q.size() == 0) begin
                    chk("ack_unexpected", {28'd0, a}, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("ack_src", {28'd0, a}, 32'd1 << e);
                    if (got > 0) chk("ack_gap", 32'(c - last), 32'(gap));
                    last = c;
                    got++;
                end
            end
        end
        if (got < n) chk("ack_timeout", 32'(got), 32'(n));
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        ifa.req = 4'd0; ifa.dst = 8'd0;
        ifb.req = 3'd0; ifb.dst = 6'd0;
        ifc.req = 4'd0; ifc.dst = 8'd0;

        // Reset state
        #2;
        chk("rst_endr",  {28'd0, ifa.endr_},  32'hF);
        chk("rst_enrec", {28'd0, ifa.enrec_}, 32'hF);
        chk("rst_be",    {28'd0, ifa.be_},    32'hF);
        chk("rst_oe",    {28'd0, ifa.oe_},    32'hF);
        chk("rst_s",     {28'd0, ifa.s},      32'h0);
        chk("rst_ack",   {28'd0, ifa.ack},    32'h0);
        chk("rst_err",   {31'd0, ifa.err},    32'h0);
        chk("rst_busy",  {31'd0, ifa.busy},   32'h0);
        step();
        rst = 1'b0;
        step();

        // Single transfer 0 -> 2
        ifa.req = 4'b0001; ifa.dst = 8'b00_00_00_10;
        step();
        chk("t1_endr",  {28'd0, ifa.endr_}, 32'hE);
        chk("t1_busy",  {31'd0, ifa.busy},  32'h1);
        chk("t1_be",    {28'd0, ifa.be_},   32'hF);
        ifa.req = 4'b0000;
        step();
        chk("t2_be",    {28'd0, ifa.be_},    32'hE);
        chk("t2_enrec", {28'd0, ifa.enrec_}, 32'hB);
        chk("t2_ack",   {28'd0, ifa.ack},    32'h1);
        chk("t2_endr",  {28'd0, ifa.endr_},  32'hF);
        chk("t2_oe",    {28'd0, ifa.oe_},    32'hF);
        step();
        chk("t3_oe",    {28'd0, ifa.oe_},  32'hB);
        chk("t3_ack",   {28'd0, ifa.ack},  32'h0);
        chk("t3_be",    {28'd0, ifa.be_},  32'hF);
        chk("t3_busy",  {31'd0, ifa.busy}, 32'h1);
        step();
        chk("t4_busy",  {31'd0, ifa.busy}, 32'h0);
        chk("t4_oe",    {28'd0, ifa.oe_},  32'hB);

        // Self transfer 3 -> 3
        ifa.req = 4'b1000; ifa.dst = 8'b11_00_00_00;
        step();
        chk("self_endr", {28'd0, ifa.endr_}, 32'h7);
        ifa.req = 4'b0000;
        step();
        chk("self_be",    {28'd0, ifa.be_},    32'h7);
        chk("self_enrec", {28'd0, ifa.enrec_}, 32'h7);
        chk("self_ack",   {28'd0, ifa.ack},    32'h8);
        step();
        chk("self_oe",    {28'd0, ifa.oe_},    32'h7);
        step();

        // All four requesting, TURN=1
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst2_oe", {28'd0, ifa.oe_}, 32'hF);
        ifa.req = 4'b1111; ifa.dst = 8'b00_11_10_01;
`ifdef AM2928_CTL_FIXPRIO_EN
        for (int i = 0; i < 5; i++) q.push_back(0);
`else
        q.push_back(0); q.push_back(1); q.push_back(2); q.push_back(3); q.push_back(0);
`endif
        run_stream(0, 5, 3, 40);
        ifa.req = 4'b0000;
        step(); step(); step();
        chk("rr_idle", {31'd0, ifa.busy}, 32'h0);

        // Reset during DRIVE
        ifa.req = 4'b0010; ifa.dst = 8'b00_00_11_00;
        step();
        chk("ab_endr", {28'd0, ifa.endr_}, 32'hD);
        ifa.req = 4'b0000;
        step();
        chk("ab_be_drive", {28'd0, ifa.be_},    32'hD);
        chk("ab_enrec_dr", {28'd0, ifa.enrec_}, 32'h7);
        #2;
        rst = 1'b1;
        #1;
        chk("ab_be",    {28'd0, ifa.be_},    32'hF);
        chk("ab_enrec", {28'd0, ifa.enrec_}, 32'hF);
        chk("ab_ack",   {28'd0, ifa.ack},    32'h0);
        chk("ab_busy",  {31'd0, ifa.busy},   32'h0);
        step();
        rst = 1'b0;
        step();
        chk("ab_post_busy", {31'd0, ifa.busy}, 32'h0);
        chk("ab_post_ack",  {28'd0, ifa.ack},  32'h0);
        ifa.req = 4'b0001; ifa.dst = 8'b00_00_00_01;
        q.push_back(0);
        run_stream(0, 1, 0, 10);
        ifa.req = 4'b0000;
        step(); step(); step();

        // Out-of-range destination on NREQ=3
        ifb.req = 3'b001; ifb.dst = 6'b00_00_11;
        step();
        chk("err_err",   {31'd0, ifb.err},    32'h1);
        chk("err_ack",   {29'd0, ifb.ack},    32'h1);
        chk("err_busy",  {31'd0, ifb.busy},   32'h0);
        chk("err_endr",  {29'd0, ifb.endr_},  32'h7);
        chk("err_be",    {29'd0, ifb.be_},    32'h7);
        chk("err_enrec", {29'd0, ifb.enrec_}, 32'h7);
        chk("err_oe",    {29'd0, ifb.oe_},    32'h7);
        ifb.req = 3'b000;
        step();
        chk("err_pulse", {31'd0, ifb.err},  32'h0);
        chk("err_ack2",  {29'd0, ifb.ack},  32'h0);
        chk("err_busy2", {31'd0, ifb.busy}, 32'h0);
        ifb.req = 3'b011; ifb.dst = 6'b00_00_01;
`ifdef AM2928_CTL_FIXPRIO_EN
        q.push_back(0);
`else
        q.push_back(1);
`endif
        run_stream(1, 1, 0, 10);
        ifb.req = 3'b000;
        step(); step(); step();

        // TURN=0 back-to-back
        ifc.req = 4'b0011; ifc.dst = 8'b00_00_00_01;
`ifdef AM2928_CTL_FIXPRIO_EN
        for (int i = 0; i < 4; i++) q.push_back(0);
`else
        q.push_back(0); q.push_back(1); q.push_back(0); q.push_back(1);
`endif
        run_stream(2, 4, 2, 20);
        ifc.req = 4'b0000;
        step(); step();
        chk("t0_idle", {31'd0, ifc.busy}, 32'h0);
        chk("q_empty", 32'(q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
